// File: rtl/target_spawn_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : target_spawn_scheduler
// Description : Paces target spawns across four slots with a gap timer and an
//               LFSR-seeded round-robin pick; turns aimed shots into kill
//               pulses and keeps a saturating hit score.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module target_spawn_scheduler #(
  parameter int GAP_CYCLES = 25000000,
  parameter int MAX_ACTIVE = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       titleoff,
  input  logic       over,
  input  logic [3:0] slot_clear,
  input  logic [3:0] slot_tar,
  input  logic       shot,
  input  logic [1:0] aim_slot,
  output logic [3:0] spawn,
  output logic [3:0] kill,
  output logic [7:0] score
);

  localparam int         CNT_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [7:0] LFSR_SEED = 8'hA5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GAP   = 2'd1,
    S_PICK  = 2'd2,
    S_SPAWN = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         idx_q, idx_d;
  logic [7:0]         lfsr_q, lfsr_d;
  logic [3:0]         kill_q, kill_d;
  logic [7:0]         score_q, score_d;
  logic               title_q;

  logic               w_run;
  logic [2:0]         w_active;
  logic               w_eligible;
  logic               w_found;
  logic [1:0]         w_pick;
  logic [1:0]         w_cand;

  // The game only advances while the title is dismissed and not over.
  assign w_run = titleoff & ~over;

  // Count busy slots and find the first clear slot at or after lfsr[1:0].
  always_comb begin
    w_active = 3'd0;
    w_found  = 1'b0;
    w_pick   = lfsr_q[1:0];
    w_cand   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      w_active = w_active + {2'b00, ~slot_clear[i]};
    end
    for (int k = 0; k < 4; k++) begin
      w_cand = lfsr_q[1:0] + 2'(k);
      if (!w_found && slot_clear[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
    w_eligible = (w_active < 3'(MAX_ACTIVE)) && w_found;
  end

  // Next-state logic: idle, gap timer, pick a slot, one spawn cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (!w_run) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_GAP;
          cnt_d   = '0;
        end
        S_GAP: begin
          if (cnt_q == CNT_LAST) begin
            state_d = S_PICK;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_PICK: begin
          if (w_eligible) begin
            idx_d   = w_pick;
            state_d = S_SPAWN;
          end
        end
        S_SPAWN: begin
          state_d = S_GAP;
          cnt_d   = '0;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Kill, score and LFSR next values; a titleoff rising edge restarts the score.
  always_comb begin
    kill_d = 4'b0000;
    if (shot && slot_tar[aim_slot] && w_run) begin
      kill_d[aim_slot] = 1'b1;
    end
    score_d = score_q;
    if (titleoff && !title_q) begin
      score_d = 8'd0;
    end else if ((kill_d != 4'b0000) && (score_q != 8'hFF)) begin
      score_d = score_q + 8'd1;
    end
    lfsr_d = lfsr_q;
    if (titleoff) begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  // All state registers, asynchronously reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      lfsr_q  <= LFSR_SEED;
      kill_q  <= 4'b0000;
      score_q <= 8'd0;
      title_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      lfsr_q  <= lfsr_d;
      kill_q  <= kill_d;
      score_q <= score_d;
      title_q <= titleoff;
    end
  end

  // Spawn pulse is decoded from the spawn state and the latched slot index.
  always_comb begin
    spawn = 4'b0000;
    if (state_q == S_SPAWN) begin
      spawn[idx_q] = 1'b1;
    end
  end

  assign kill  = kill_q;
  assign score = score_q;

endmodule
`default_nettype wire

// File: tb/tb_target_spawn_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : tb_target_spawn_scheduler
// Description : Self-checking bench for target_spawn_scheduler (GAP=4, MAX=3).
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_target_spawn_scheduler;

  localparam int GAP = 4;
  localparam int MAXA = 3;

  logic       clk;
  logic       resetn;
  logic       titleoff;
  logic       over;
  logic [3:0] slot_clear;
  logic [3:0] slot_tar;
  logic       shot;
  logic [1:0] aim_slot;
  logic [3:0] spawn;
  logic [3:0] kill;
  logic [7:0] score;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: phase -1 = idle, 0..GAP-1 = waiting, GAP = picking,
  // GAP+1 = spawning
  int m_ph, m_idx, m_lfsr, m_score, m_kill, m_tprev;

  typedef struct {
    logic       t;
    logic       o;
    logic [3:0] tar;
    logic       sh;
    logic [1:0] aim;
    logic [3:0] ekill;
    logic [7:0] escore;
  } vec_t;

  vec_t tbl[10];

  target_spawn_scheduler #(.GAP_CYCLES(GAP), .MAX_ACTIVE(MAXA)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .titleoff   (titleoff),
    .over       (over),
    .slot_clear (slot_clear),
    .slot_tar   (slot_tar),
    .shot       (shot),
    .aim_slot   (aim_slot),
    .spawn      (spawn),
    .kill       (kill),
    .score      (score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic void model_reset();
    m_ph = -1; m_idx = 0; m_lfsr = 8'hA5; m_score = 0; m_kill = 0; m_tprev = 0;
  endfunction

  function automatic void model_update();
    int run, nk, busy, fb;
    run = (titleoff && !over) ? 1 : 0;
    nk = (shot && slot_tar[aim_slot] && run != 0) ? (1 << aim_slot) : 0;
    if (titleoff && m_tprev == 0) m_score = 0;
    else if (nk != 0 && m_score < 255) m_score = m_score + 1;
    m_kill = nk;
    if (run == 0) m_ph = -1;
    else if (m_ph == -1) m_ph = 0;
    else if (m_ph < GAP) m_ph = m_ph + 1;
    else if (m_ph == GAP) begin
      busy = 0;
      for (int i = 0; i < 4; i++) if (!slot_clear[i]) busy++;
      if (busy < MAXA && slot_clear != 4'b0000) begin
        for (int k = 3; k >= 0; k--) begin
          if (slot_clear[(m_lfsr + k) % 4]) m_idx = (m_lfsr + k) % 4;
        end
        m_ph = GAP + 1;
      end
    end else m_ph = 0;
    m_tprev = titleoff ? 1 : 0;
    if (titleoff) begin
      fb = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
      m_lfsr = ((m_lfsr << 1) | fb) & 255;
    end
  endfunction

  function automatic logic [3:0] exp_spawn();
    return (m_ph == GAP + 1) ? 4'(1 << m_idx) : 4'b0000;
  endfunction

  // one clock: advance model with the sampled inputs, then compare outputs
  task automatic step();
    @(posedge clk);
    if (!resetn) model_reset();
    else model_update();
    #1;
    check("spawn", {4'h0, spawn}, {4'h0, exp_spawn()});
    check("kill", {4'h0, kill}, 8'(m_kill));
    check("score", score, 8'(m_score));
  endtask

  task automatic set_in(input logic t, input logic o, input logic [3:0] clr,
                        input logic [3:0] tar, input logic sh, input logic [1:0] aim);
    titleoff = t; over = o; slot_clear = clr; slot_tar = tar; shot = sh; aim_slot = aim;
  endtask

  initial begin
    logic got;
    logic [3:0] clr_r;
    tbl[0] = '{1'b1, 1'b0, 4'b0010, 1'b1, 2'd1, 4'b0010, 8'd1};
    tbl[1] = '{1'b1, 1'b0, 4'b0010, 1'b1, 2'd2, 4'b0000, 8'd1};
    tbl[2] = '{1'b1, 1'b0, 4'b0010, 1'b0, 2'd1, 4'b0000, 8'd1};
    tbl[3] = '{1'b1, 1'b0, 4'b1000, 1'b1, 2'd3, 4'b1000, 8'd2};
    tbl[4] = '{1'b1, 1'b1, 4'b1000, 1'b1, 2'd3, 4'b0000, 8'd2};
    tbl[5] = '{1'b1, 1'b0, 4'b1111, 1'b1, 2'd0, 4'b0001, 8'd3};
    tbl[6] = '{1'b0, 1'b0, 4'b1111, 1'b1, 2'd0, 4'b0000, 8'd3};
    tbl[7] = '{1'b1, 1'b0, 4'b1111, 1'b0, 2'd0, 4'b0000, 8'd0};
    tbl[8] = '{1'b1, 1'b0, 4'b0100, 1'b1, 2'd2, 4'b0100, 8'd1};
    tbl[9] = '{1'b1, 1'b0, 4'b0000, 1'b1, 2'd2, 4'b0000, 8'd1};

    model_reset();
    resetn = 1'b0;
    set_in(1'b0, 1'b0, 4'b1111, 4'b0000, 1'b0, 2'd0);
    step(); step();
    check("reset_spawn", {4'h0, spawn}, 8'h00);
    check("reset_kill", {4'h0, kill}, 8'h00);
    check("reset_score", score, 8'h00);

    // release between edges; one idle cycle with no pulses
    @(negedge clk); resetn = 1'b1;
    step();

    // first spawn after idle, four gap cycles and one pick cycle
    set_in(1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0, 2'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("first_spawn_early", {4'h0, spawn}, 8'h00);
    end
    step();
    check("first_spawn", {4'h0, spawn}, 8'h02);

    // kill/score vectors with no clear slots so nothing spawns
    for (int i = 0; i < 10; i++) begin
      set_in(tbl[i].t, tbl[i].o, 4'b0000, tbl[i].tar, tbl[i].sh, tbl[i].aim);
      step();
      check($sformatf("tbl%0d_kill", i), {4'h0, kill}, {4'h0, tbl[i].ekill});
      check($sformatf("tbl%0d_score", i), score, tbl[i].escore);
    end

    // score saturation
    for (int i = 0; i < 260; i++) begin
      set_in(1'b1, 1'b0, 4'b0000, 4'b1111, 1'b1, 2'($urandom_range(0, 3)));
      step();
    end
    check("score_sat", score, 8'd255);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      clr_r = 4'($urandom);
      set_in(($urandom_range(0, 99) != 0), ($urandom_range(0, 99) < 2), clr_r,
             4'($urandom) & ~clr_r, ($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)));
      step();
    end

    // too many busy slots: hold in pick until one frees up
    set_in(1'b1, 1'b0, 4'b1000, 4'b0000, 1'b0, 2'd0);
    for (int i = 0; i < 20; i++) begin
      step();
      if (i > 1) check("hold_pick", {4'h0, spawn}, 8'h00);
    end
    slot_clear = 4'b1001;
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      step();
      if (spawn != 4'b0000) got = 1'b1;
    end
    check("release_spawn_seen", {7'h0, got}, 8'h01);

    // over during an eligible pick: no spawn, no kill
    set_in(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0);
    for (int i = 0; i < 7; i++) step();
    set_in(1'b1, 1'b1, 4'b1111, 4'b0010, 1'b1, 2'd1);
    step();
    check("over_spawn", {4'h0, spawn}, 8'h00);
    check("over_kill", {4'h0, kill}, 8'h00);
    set_in(1'b1, 1'b0, 4'b0000, 4'b0010, 1'b1, 2'd1);
    step();
    check("hit_before_rst", {4'h0, kill}, 8'h02);
    shot = 1'b0;
    step(); step();

    // asynchronous reset in the middle of a gap
    @(posedge clk); model_update(); #3;
    resetn = 1'b0;
    #1;
    model_reset();
    check("arst_spawn", {4'h0, spawn}, 8'h00);
    check("arst_kill", {4'h0, kill}, 8'h00);
    check("arst_score", score, 8'h00);
    @(negedge clk); resetn = 1'b1;

    // titleoff 0->1 clears a nonzero score
    set_in(1'b1, 1'b0, 4'b0000, 4'b0100, 1'b1, 2'd2);
    step(); step(); step();
    check("score_before_toggle", score, 8'd2);
    set_in(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0);
    step();
    titleoff = 1'b1;
    step();
    check("toggle_clear", score, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
